// File: rtl/ama_riscv_hazard_pkg.sv
// AMA-RISCV hazard unit shared types: stall causes and fwd_sel encoding.
// Used by ama_riscv_hazard_unit and ama_riscv_mc_scoreboard.
package ama_riscv_hazard_pkg;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    LOAD_USE  = 2'd1,
    MC_RAW    = 2'd2,
    MC_STRUCT = 2'd3
  } stall_cause_e;

  localparam int FWD_RF     = 0;
  localparam int FWD_MC_OFS = 1;

  function automatic int fwd_sw(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/ama_riscv_mc_scoreboard.sv
// Multi-cycle op tracking: per-register pending bitmap, busy flag and
// latency watchdog. Only built when AMA_RISCV_MC_SCOREBOARD_EN is defined.
module ama_riscv_mc_scoreboard #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   set_i,
  input  logic [REG_AW-1:0]      set_rd_i,
  input  logic                   done_i,
  input  logic [REG_AW-1:0]      done_rd_i,
  output logic [2**REG_AW-1:0]   pending_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int NREG = 2 ** REG_AW;
  localparam int CW   = $clog2(MC_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MC_LAT);

  logic [NREG-1:0] pend_q, pend_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
  logic            done_v;

  // a completion with nothing outstanding is stale and dropped
  assign done_v = done_i & busy_q;

  always_comb begin
    pend_d = pend_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    tmo_d  = tmo_q;
    if (busy_q && !done_v && cnt_q == LAT)
      tmo_d = 1'b1;
    if (done_v) begin
      pend_d[done_rd_i] = 1'b0;
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q && cnt_q != LAT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (set_i) begin
      busy_d = 1'b1;
      cnt_d  = CW'(1);
      if (set_rd_i != '0)
        pend_d[set_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      tmo_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign pending_o = pend_q;
  assign busy_o    = busy_q;
  assign timeout_o = tmo_q;

endmodule

// File: rtl/ama_riscv_hazard_unit.sv
// AMA-RISCV ID-stage hazard unit: operand forwarding, load-use and MC stalls.
// MC scoreboard enabled by defining AMA_RISCV_MC_SCOREBOARD_EN.
module ama_riscv_hazard_unit
  import ama_riscv_hazard_pkg::*;
#(
  parameter int  NUM_SRC   = 2,
  parameter int  FWD_DEPTH = 2,
  parameter int  MC_LAT    = 8,
  parameter int  REG_AW    = 5,
  localparam int FSW       = fwd_sw(FWD_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_SRC*REG_AW-1:0] rs_id_i,
  input  logic [NUM_SRC-1:0]        rs_used_id_i,
  input  logic [REG_AW-1:0]         rd_id_i,
  input  logic                      mc_id_i,
  input  logic                      issue_i,
  input  logic                      flush_i,
  input  logic [FWD_DEPTH*REG_AW-1:0] rd_stg_i,
  input  logic [FWD_DEPTH-1:0]      we_stg_i,
  input  logic                      load_stg0_i,
  input  logic                      mc_done_i,
  input  logic [REG_AW-1:0]         mc_rd_i,
  output logic [NUM_SRC*FSW-1:0]    fwd_sel_o,
  output logic                      stall_o,
  output logic [1:0]                stall_cause_o,
  output logic                      mc_busy_o,
  output logic                      mc_timeout_o
);

  localparam int NREG   = 2 ** REG_AW;
  localparam int FWD_MC = FWD_DEPTH + FWD_MC_OFS;

  logic [REG_AW-1:0]      rs;
  logic [FSW-1:0]         sel;
  logic [NUM_SRC*FSW-1:0] fwd;
  logic [NUM_SRC-1:0]     lu;
  logic [NUM_SRC-1:0]     raw;
  logic [NREG-1:0]        pend;
  logic                   done_v;
  logic                   strct;
  stall_cause_e           cause;

`ifdef AMA_RISCV_MC_SCOREBOARD_EN
  logic busy;
  logic set_v;

  assign done_v = mc_done_i & busy;
  assign strct  = mc_id_i & busy & ~done_v;
  assign set_v  = issue_i & mc_id_i & ~flush_i & ~stall_o;

  ama_riscv_mc_scoreboard #(
    .REG_AW (REG_AW),
    .MC_LAT (MC_LAT)
  ) u_sb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .set_i     (set_v),
    .set_rd_i  (rd_id_i),
    .done_i    (mc_done_i),
    .done_rd_i (mc_rd_i),
    .pending_o (pend),
    .busy_o    (busy),
    .timeout_o (mc_timeout_o)
  );

  assign mc_busy_o = busy;
`else
  localparam int unused_lat = MC_LAT;
  logic unused_mc;

  assign unused_mc = ^{clk_i, issue_i, flush_i, mc_id_i,
                       rd_id_i, mc_done_i, mc_rd_i};
  assign done_v       = 1'b0;
  assign strct        = 1'b0;
  assign pend         = '0;
  assign mc_busy_o    = 1'b0;
  assign mc_timeout_o = 1'b0;
`endif

  // descending scan so the youngest matching stage wins
  always_comb begin
    fwd = '0;
    lu  = '0;
    raw = '0;
    rs  = '0;
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs  = rs_id_i[i*REG_AW +: REG_AW];
      sel = FSW'(FWD_RF);
      if (rs_used_id_i[i] && rs != '0) begin
        for (int k = FWD_DEPTH - 1; k >= 0; k--)
          if (we_stg_i[k] && rd_stg_i[k*REG_AW +: REG_AW] == rs)
            sel = FSW'(k + 1);
        if (sel == FSW'(FWD_RF) && done_v && mc_rd_i == rs)
          sel = FSW'(FWD_MC);
        lu[i]  = we_stg_i[0] & load_stg0_i &
                 (rd_stg_i[REG_AW-1:0] == rs);
        raw[i] = pend[rs] & ~(done_v & (mc_rd_i == rs));
      end
      fwd[i*FSW +: FSW] = sel;
    end
  end

  always_comb begin
    cause = NONE;
    if (|lu)
      cause = LOAD_USE;
    else if (|raw)
      cause = MC_RAW;
    else if (strct)
      cause = MC_STRUCT;
    if (!rst_ni)
      cause = NONE;
  end

  assign stall_o       = (cause != NONE);
  assign stall_cause_o = cause;
  assign fwd_sel_o     = rst_ni ? fwd : '0;

endmodule

// File: tb/tb_ama_riscv_hazard_unit.sv
// Self-checking bench for ama_riscv_hazard_unit (default parameters).
// Expectations adapt to whether AMA_RISCV_MC_SCOREBOARD_EN is defined.
module tb_ama_riscv_hazard_unit;

`ifdef AMA_RISCV_MC_SCOREBOARD_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif
  localparam int MC_LAT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rs_id;
  logic [1:0] rs_used;
  logic [4:0] rd_id;
  logic       mc_id, issue, flush;
  logic [9:0] rd_stg;
  logic [1:0] we_stg;
  logic       load_stg0;
  logic       mc_done;
  logic [4:0] mc_rd;
  logic [3:0] fwd_sel;
  logic       stall;
  logic [1:0] stall_cause;
  logic       mc_busy, mc_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  bit         m_pend[32];
  bit         m_busy;
  bit         m_tmo;
  int         m_age;
  logic [4:0] m_rd;
  logic [3:0] e_fwd;
  logic [1:0] e_cause;
  logic       e_stall;

  ama_riscv_hazard_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rs_id_i       (rs_id),
    .rs_used_id_i  (rs_used),
    .rd_id_i       (rd_id),
    .mc_id_i       (mc_id),
    .issue_i       (issue),
    .flush_i       (flush),
    .rd_stg_i      (rd_stg),
    .we_stg_i      (we_stg),
    .load_stg0_i   (load_stg0),
    .mc_done_i     (mc_done),
    .mc_rd_i       (mc_rd),
    .fwd_sel_o     (fwd_sel),
    .stall_o       (stall),
    .stall_cause_o (stall_cause),
    .mc_busy_o     (mc_busy),
    .mc_timeout_o  (mc_timeout)
  );

  always #5 clk = ~clk;

  // Reference: priority rules applied per source, state kept as plain flags.
  function automatic void model_eval();
    logic [4:0] r;
    logic [1:0] s;
    bit lu, raw, st, dv;
    dv = MC_EN && mc_done && m_busy;
    lu = 0;
    raw = 0;
    e_fwd = '0;
    for (int i = 0; i < 2; i++) begin
      r = rs_id[i*5 +: 5];
      s = 2'd0;
      if (rs_used[i] && r != 5'd0) begin
        for (int k = 0; k < 2; k++)
          if (s == 2'd0 && we_stg[k] && rd_stg[k*5 +: 5] == r)
            s = 2'(k + 1);
        if (s == 2'd0 && dv && mc_rd == r) s = 2'd3;
        if (we_stg[0] && load_stg0 && rd_stg[4:0] == r) lu = 1;
        if (MC_EN && m_pend[r] && !(dv && mc_rd == r)) raw = 1;
      end
      e_fwd[i*2 +: 2] = s;
    end
    st = MC_EN && mc_id && m_busy && !dv;
    e_cause = lu ? 2'd1 : raw ? 2'd2 : st ? 2'd3 : 2'd0;
    if (!rst_n) begin
      e_cause = 2'd0;
      e_fwd = '0;
    end
    e_stall = (e_cause != 2'd0);
  endfunction

  function automatic void model_edge();
    bit dv, acc;
    model_eval();
    if (!rst_n) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_busy = 0;
      m_tmo = 0;
      m_age = 0;
      return;
    end
    if (!MC_EN) return;
    dv = mc_done && m_busy;
    acc = issue && mc_id && !flush && !e_stall;
    if (m_busy && !dv) begin
      if (m_age >= MC_LAT) m_tmo = 1;
      m_age++;
    end
    if (dv) begin
      m_pend[mc_rd] = 0;
      m_busy = 0;
    end
    if (acc) begin
      m_busy = 1;
      m_age = 1;
      m_rd = rd_id;
      if (rd_id != 5'd0) m_pend[rd_id] = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rs_id = '0; rs_used = '0; rd_id = '0;
    mc_id = 0; issue = 0; flush = 0;
    rd_stg = '0; we_stg = '0; load_stg0 = 0;
    mc_done = 0; mc_rd = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    rs_id = 10'd5; rs_used = 2'b01;
    rd_stg = {5'd5, 5'd5}; we_stg = 2'b11; load_stg0 = 1;
    #1;
    n_chk++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || stall_cause !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_comb: fwd=%h stall=%b cause=%0d want 0/0/0",
               fwd_sel, stall, stall_cause);
    end
    tick();
    tick();
    n_chk++;
    if (mc_busy !== 1'b0 || mc_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b tmo=%b want 0/0",
               mc_busy, mc_timeout);
    end
    rst_n = 1;
    idle();
    tick();
  endtask

  task automatic test_fwd_priority();
    idle();
    rs_id = {5'd0, 5'd5}; rs_used = 2'b11;
    rd_stg = {5'd5, 5'd5}; we_stg = 2'b11;
    #1;
    n_chk++;
    if (fwd_sel !== 4'b0001 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_ex_wins: fwd=%b stall=%b want 0001/0", fwd_sel, stall);
    end
    we_stg = 2'b10;
    #1;
    n_chk++;
    if (fwd_sel !== 4'b0010) begin
      n_fail++;
      $display("FAIL fwd_mem: fwd=%b want 0010", fwd_sel);
    end
    rs_id = {5'd5, 5'd5}; rs_used = 2'b01; we_stg = 2'b11;
    #1;
    n_chk++;
    if (fwd_sel !== 4'b0001) begin
      n_fail++;
      $display("FAIL fwd_unused_src: fwd=%b want 0001", fwd_sel);
    end
    rs_id = 10'd0; rs_used = 2'b11; rd_stg = 10'd0;
    #1;
    n_chk++;
    if (fwd_sel !== 4'b0000) begin
      n_fail++;
      $display("FAIL fwd_x0: fwd=%b want 0000", fwd_sel);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    rs_id = {5'd7, 5'd3}; rs_used = 2'b10;
    rd_stg = {5'd0, 5'd7}; we_stg = 2'b01; load_stg0 = 1;
    #1;
    n_chk++;
    if (stall !== 1'b1 || stall_cause !== 2'd1) begin
      n_fail++;
      $display("FAIL load_use: stall=%b cause=%0d want 1/1", stall, stall_cause);
    end
    tick();
    rd_stg = {5'd7, 5'd0}; we_stg = 2'b10; load_stg0 = 0;
    #1;
    n_chk++;
    if (stall !== 1'b0 || fwd_sel[3:2] !== 2'd2) begin
      n_fail++;
      $display("FAIL load_use_next: stall=%b fwd1=%0d want 0/2",
               stall, fwd_sel[3:2]);
    end
    tick();
  endtask

  task automatic test_mc_raw();
    idle();
    issue = 1; mc_id = 1; rd_id = 5'd9;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_issue: stall=%b want 0", stall);
    end
    tick();
    idle();
    rs_id = 10'd9; rs_used = 2'b01;
    for (int c = 1; c < 4; c++) begin
      #1;
      n_chk++;
      if (stall !== MC_EN || stall_cause !== (MC_EN ? 2'd2 : 2'd0) ||
          mc_busy !== MC_EN) begin
        n_fail++;
        $display("FAIL mc_raw c%0d: stall=%b cause=%0d busy=%b want %b/%0d/%b",
                 c, stall, stall_cause, mc_busy, MC_EN,
                 MC_EN ? 2 : 0, MC_EN);
      end
      tick();
    end
    mc_done = 1; mc_rd = 5'd9;
    #1;
    n_chk++;
    if (stall !== 1'b0 || fwd_sel[1:0] !== (MC_EN ? 2'd3 : 2'd0)) begin
      n_fail++;
      $display("FAIL mc_bypass: stall=%b fwd0=%0d want 0/%0d",
               stall, fwd_sel[1:0], MC_EN ? 3 : 0);
    end
    tick();
    mc_done = 0; mc_rd = '0;
    #1;
    n_chk++;
    if (stall !== 1'b0 || mc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_cleared: stall=%b busy=%b want 0/0", stall, mc_busy);
    end
    tick();
  endtask

  task automatic test_mc_struct();
    idle();
    issue = 1; mc_id = 1; rd_id = 5'd10;
    #1;
    tick();
    rd_id = 5'd11;
    #1;
    n_chk++;
    if (stall !== MC_EN || stall_cause !== (MC_EN ? 2'd3 : 2'd0)) begin
      n_fail++;
      $display("FAIL mc_struct: stall=%b cause=%0d want %b/%0d",
               stall, stall_cause, MC_EN, MC_EN ? 3 : 0);
    end
    tick();
    mc_done = 1; mc_rd = 5'd10;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_struct_done: stall=%b want 0", stall);
    end
    tick();
    idle();
    rs_id = 10'd11; rs_used = 2'b01;
    #1;
    n_chk++;
    if (mc_busy !== MC_EN || stall_cause !== (MC_EN ? 2'd2 : 2'd0)) begin
      n_fail++;
      $display("FAIL mc_reissue: busy=%b cause=%0d want %b/%0d",
               mc_busy, stall_cause, MC_EN, MC_EN ? 2 : 0);
    end
    mc_done = 1; mc_rd = 5'd11;
    #1;
    tick();
    idle();
    #1;
    n_chk++;
    if (mc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mc_struct_end: busy=%b want 0", mc_busy);
    end
    tick();
  endtask

  task automatic test_set_wins();
    idle();
    issue = 1; mc_id = 1; rd_id = 5'd13;
    #1;
    tick();
    mc_done = 1; mc_rd = 5'd13;
    #1;
    tick();
    idle();
    rs_id = {5'd13, 5'd0}; rs_used = 2'b10;
    #1;
    n_chk++;
    if (stall_cause !== (MC_EN ? 2'd2 : 2'd0) || mc_busy !== MC_EN) begin
      n_fail++;
      $display("FAIL set_wins: cause=%0d busy=%b want %0d/%b",
               stall_cause, mc_busy, MC_EN ? 2 : 0, MC_EN);
    end
    mc_done = 1; mc_rd = 5'd13;
    #1;
    tick();
    idle();
    tick();
  endtask

  task automatic test_timeout();
    idle();
    issue = 1; mc_id = 1; rd_id = 5'd12;
    #1;
    tick();
    idle();
    for (int c = 1; c <= MC_LAT; c++) begin
      #1;
      n_chk++;
      if (mc_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_early c%0d: tmo=%b want 0", c, mc_timeout);
      end
      tick();
    end
    n_chk++;
    if (mc_timeout !== MC_EN) begin
      n_fail++;
      $display("FAIL tmo_set: tmo=%b want %b", mc_timeout, MC_EN);
    end
    mc_done = 1; mc_rd = 5'd12;
    tick();
    idle();
    tick();
    n_chk++;
    if (mc_timeout !== MC_EN || mc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_sticky: tmo=%b busy=%b want %b/0",
               mc_timeout, mc_busy, MC_EN);
    end
    rst_n = 0;
    rs_id = 10'd5; rs_used = 2'b01; rd_stg = 10'd5; we_stg = 2'b01;
    load_stg0 = 1;
    #1;
    n_chk++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || stall_cause !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_outs: fwd=%h stall=%b cause=%0d want 0/0/0",
               fwd_sel, stall, stall_cause);
    end
    tick();
    rst_n = 1;
    idle();
    mc_done = 1; mc_rd = 5'd5; rs_id = 10'd5; rs_used = 2'b01;
    #1;
    n_chk++;
    if (mc_busy !== 1'b0 || mc_timeout !== 1'b0 || fwd_sel !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_late_done: busy=%b tmo=%b fwd=%h want 0/0/0",
               mc_busy, mc_timeout, fwd_sel);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_flush();
    idle();
    issue = 1; mc_id = 1; flush = 1; rd_id = 5'd4;
    #1;
    tick();
    idle();
    rs_id = 10'd4; rs_used = 2'b01;
    #1;
    n_chk++;
    if (stall !== 1'b0 || mc_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_issue: stall=%b busy=%b want 0/0", stall, mc_busy);
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      rs_id     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rs_used   = 2'($urandom);
      rd_id     = 5'($urandom_range(0, 7));
      mc_id     = ($urandom_range(0, 2) == 0);
      issue     = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 7) == 0);
      rd_stg    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      we_stg    = 2'($urandom);
      load_stg0 = ($urandom_range(0, 2) == 0);
      mc_done   = ($urandom_range(0, 3) == 0);
      mc_rd     = ($urandom_range(0, 3) != 0) ? m_rd
                                              : 5'($urandom_range(0, 7));
      #1;
      model_eval();
      n_chk++;
      if (fwd_sel !== e_fwd || stall !== e_stall ||
          stall_cause !== e_cause ||
          mc_busy !== 1'(MC_EN && m_busy) ||
          mc_timeout !== 1'(MC_EN && m_tmo)) begin
        n_fail++;
        $display("FAIL rand n%0d: fwd=%h stall=%b cause=%0d busy=%b tmo=%b want %h/%b/%0d/%b/%b",
                 n, fwd_sel, stall, stall_cause, mc_busy, mc_timeout,
                 e_fwd, e_stall, e_cause, MC_EN && m_busy, MC_EN && m_tmo);
      end
      tick();
    end
    rst_n = 1;
    idle();
  endtask

  initial begin
    rst_n = 0;
    m_rd = '0;
    idle();
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_mc_raw();
    test_mc_struct();
    test_set_wins();
    test_timeout();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
